// File: rtl/song_sequencer.sv
// Walks one song's {note, duration} list in a synchronous ROM and hands each
// entry to the note player with a registered one-cycle load strobe.
module song_sequencer #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic [1:0]                song,
  input  logic                      note_done,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [2+IDX_W-1:0]        rom_addr,
  output logic                      new_note,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      song_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_ISSUE, S_WAIT_NOTE, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [NOTE_W-1:0]  r_note;
  logic [DUR_W-1:0]   r_dur;
  logic               r_new_note, r_song_done;

  logic [NOTE_W-1:0]  w_rom_note;
  logic [DUR_W-1:0]   w_rom_dur;
  logic               w_last, w_latch, w_adv;

  assign w_rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur  = rom_data[DUR_W-1:0];
  assign w_last     = &r_idx;

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_adv   = 1'b0;
    case (r_state)
      S_IDLE:     if (play) w_next = S_FETCH;
      S_FETCH:    if (play) w_next = S_WAIT_ROM;
      // duration 0 terminates the list; its note field is never loaded
      S_WAIT_ROM: begin
        if (w_rom_dur == '0) w_next = S_DONE;
        else begin
          w_next  = S_ISSUE;
          w_latch = 1'b1;
        end
      end
      S_ISSUE:    w_next = S_WAIT_NOTE;
      S_WAIT_NOTE: begin
        if (note_done) begin
          if (w_last) w_next = S_DONE;
          else begin
            w_next = S_FETCH;
            w_adv  = 1'b1;
          end
        end
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Strobes are registered off the state so a reset clears any pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_note      <= '0;
      r_dur       <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_new_note  <= (r_state == S_ISSUE);
      r_song_done <= (r_state == S_DONE);
      if (w_latch) begin
        r_note <= w_rom_note;
        r_dur  <= w_rom_dur;
      end
      if (w_adv)                 r_idx <= r_idx + 1'b1;
      else if (r_state == S_DONE) r_idx <= '0;
    end
  end

  assign rom_addr  = {song, r_idx};
  assign new_note  = r_new_note;
  assign song_done = r_song_done;
  assign note      = r_note;
  assign duration  = r_dur;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a behavioural synchronous song ROM.
module tb_song_sequencer;
  logic        clk = 1'b0, reset = 1'b1, play = 1'b0, note_done = 1'b0;
  logic [1:0]  song = 2'd0;
  logic [11:0] rom_data;
  logic [6:0]  rom_addr;
  logic        new_note, song_done;
  logic [5:0]  note, duration;

  logic [11:0] rom [128];
  int errors = 0, checks = 0, cnt_new = 0, cnt_done = 0;
  bit both_hi = 1'b0;

  song_sequencer dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
    .rom_data(rom_data), .rom_addr(rom_addr), .new_note(new_note),
    .note(note), .duration(duration), .song_done(song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(negedge clk) begin
    if (new_note) cnt_new++;
    if (song_done) cnt_done++;
    if (new_note && song_done) both_hi = 1'b1;
  end

  task tick();
    @(posedge clk); #1;
  endtask

  task do_reset(input logic [1:0] s);
    reset = 1'b1; play = 1'b0; note_done = 1'b0; song = s;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Plays with an immediate note_done per strobe; mimics the MCU reset on song_done.
  task run_song(input int max_cyc, output logic [6:0] addr_at_done, output bit to);
    bit done;
    done = 1'b0; to = 1'b1; addr_at_done = '0; play = 1'b1;
    for (int i = 0; i < max_cyc && !done; i++) begin
      tick();
      if (song_done) begin
        addr_at_done = rom_addr; play = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0; done = 1'b1; to = 1'b0;
      end else if (new_note) begin
        note_done = 1'b1; tick(); note_done = 1'b0;
      end
    end
  endtask

  task test_reset();
    do_reset(2'd0);
    checks++; if (rom_addr !== 7'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", rom_addr); end
    checks++; if (note !== 6'd0) begin errors++; $display("FAIL reset_note: got %0d expected 0", note); end
    checks++; if (duration !== 6'd0) begin errors++; $display("FAIL reset_dur: got %0d expected 0", duration); end
    checks++; if (new_note !== 1'b0) begin errors++; $display("FAIL reset_new_note: got %b expected 0", new_note); end
    checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL reset_song_done: got %b expected 0", song_done); end
  endtask

  task test_basic();
    rom[7'b10_00000] = {6'd10, 6'd4};
    rom[7'b10_00001] = {6'd11, 6'd3};
    do_reset(2'd2);
    play = 1'b1;
    tick();
    checks++; if (rom_addr !== 7'b10_00000) begin errors++; $display("FAIL basic_addr0: got %b expected 1000000", rom_addr); end
    tick(); tick();
    checks++; if (new_note !== 1'b0) begin errors++; $display("FAIL basic_early_strobe: got %b expected 0", new_note); end
    tick();
    checks++; if (new_note !== 1'b1) begin errors++; $display("FAIL basic_strobe_lat: got %b expected 1", new_note); end
    checks++; if (note !== 6'd10) begin errors++; $display("FAIL basic_note: got %0d expected 10", note); end
    checks++; if (duration !== 6'd4) begin errors++; $display("FAIL basic_dur: got %0d expected 4", duration); end
    tick();
    checks++; if (new_note !== 1'b0) begin errors++; $display("FAIL basic_strobe_width: got %b expected 0", new_note); end
    note_done = 1'b1; tick(); note_done = 1'b0;
    checks++; if (rom_addr !== 7'b10_00001) begin errors++; $display("FAIL basic_addr1: got %b expected 1000001", rom_addr); end
    tick(); tick();
    checks++; if (new_note !== 1'b0) begin errors++; $display("FAIL basic_next_early: got %b expected 0", new_note); end
    tick();
    checks++; if (new_note !== 1'b1) begin errors++; $display("FAIL basic_next_lat: got %b expected 1", new_note); end
    checks++; if ({note, duration} !== {6'd11, 6'd3}) begin errors++; $display("FAIL basic_next_entry: got %0d/%0d expected 11/3", note, duration); end
  endtask

  task test_end_marker();
    int nb, db; logic [6:0] ad; bit to;
    rom[7'b01_00011] = {6'd5, 6'd0};
    do_reset(2'd1);
    nb = cnt_new; db = cnt_done;
    run_song(300, ad, to);
    repeat (6) tick();
    checks++; if (to) begin errors++; $display("FAIL end_timeout: got no song_done expected song_done"); end
    checks++; if (cnt_new - nb !== 3) begin errors++; $display("FAIL end_notes: got %0d expected 3", cnt_new - nb); end
    checks++; if (cnt_done - db !== 1) begin errors++; $display("FAIL end_done_cnt: got %0d expected 1", cnt_done - db); end
    checks++; if (note !== 6'd0) begin errors++; $display("FAIL end_marker_note_after_reset: got %0d expected 0", note); end
  endtask

  task test_full();
    int nb, db; logic [6:0] ad; bit to;
    do_reset(2'd3);
    nb = cnt_new; db = cnt_done;
    run_song(1000, ad, to);
    repeat (6) tick();
    checks++; if (to) begin errors++; $display("FAIL full_timeout: got no song_done expected song_done"); end
    checks++; if (cnt_new - nb !== 32) begin errors++; $display("FAIL full_notes: got %0d expected 32", cnt_new - nb); end
    checks++; if (cnt_done - db !== 1) begin errors++; $display("FAIL full_done_cnt: got %0d expected 1", cnt_done - db); end
    checks++; if (ad !== 7'b11_00000) begin errors++; $display("FAIL full_idx_return: got %b expected 1100000", ad); end
  endtask

  task test_pause();
    int nb, lat; bit seen;
    do_reset(2'd0);
    play = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); if (new_note) seen = 1'b1; end
    checks++; if (!seen) begin errors++; $display("FAIL pause_first_timeout: got no strobe expected strobe"); end
    play = 1'b0; tick();
    note_done = 1'b1; tick(); note_done = 1'b0;
    checks++; if (rom_addr !== 7'b00_00001) begin errors++; $display("FAIL pause_addr: got %b expected 0000001", rom_addr); end
    nb = cnt_new;
    repeat (5) tick();
    checks++; if (cnt_new - nb !== 0) begin errors++; $display("FAIL pause_hold: got %0d strobes expected 0", cnt_new - nb); end
    play = 1'b1; lat = 0; seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin tick(); if (new_note) begin seen = 1'b1; lat = i; end end
    checks++; if (lat !== 3) begin errors++; $display("FAIL pause_resume_lat: got %0d expected 3", lat); end
    checks++; if ({note, duration} !== {6'd1, 6'd2}) begin errors++; $display("FAIL pause_entry: got %0d/%0d expected 1/2", note, duration); end
  endtask

  task test_reset_mid();
    int hits, db;
    do_reset(2'd2);
    play = 1'b1; hits = 0;
    for (int i = 0; i < 300 && hits < 6; i++) begin
      tick();
      if (new_note) begin
        hits++;
        if (hits < 6) begin note_done = 1'b1; tick(); note_done = 1'b0; end
      end
    end
    checks++; if (hits !== 6) begin errors++; $display("FAIL mid_reach_idx5: got %0d strobes expected 6", hits); end
    checks++; if (rom_addr !== 7'b10_00101) begin errors++; $display("FAIL mid_addr5: got %b expected 1000101", rom_addr); end
    db = cnt_done;
    reset = 1'b1; play = 1'b0; tick(); reset = 1'b0;
    checks++; if (rom_addr !== 7'b10_00000) begin errors++; $display("FAIL mid_addr_cleared: got %b expected 1000000", rom_addr); end
    checks++; if ({note, duration} !== 12'd0) begin errors++; $display("FAIL mid_outputs_cleared: got %0d/%0d expected 0/0", note, duration); end
    repeat (4) tick();
    checks++; if (cnt_done - db !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", cnt_done - db); end
    // reset landing on the ISSUE cycle must swallow the pending strobe
    play = 1'b1; tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0; play = 1'b0;
    checks++; if (new_note !== 1'b0) begin errors++; $display("FAIL mid_strobe_suppressed: got %b expected 0", new_note); end
  endtask

  task test_spurious();
    int nb, db;
    do_reset(2'd1);
    nb = cnt_new; db = cnt_done;
    note_done = 1'b1; tick(); note_done = 1'b0; tick();
    checks++; if (rom_addr !== 7'b01_00000) begin errors++; $display("FAIL spur_idle_idx: got %b expected 0100000", rom_addr); end
    play = 1'b1; tick(); play = 1'b0;
    note_done = 1'b1; tick(); note_done = 1'b0;
    repeat (4) tick();
    checks++; if (rom_addr !== 7'b01_00000) begin errors++; $display("FAIL spur_fetch_idx: got %b expected 0100000", rom_addr); end
    checks++; if ((cnt_new - nb) + (cnt_done - db) !== 0) begin errors++; $display("FAIL spur_strobes: got %0d expected 0", (cnt_new - nb) + (cnt_done - db)); end
    checks++; if (both_hi !== 1'b0) begin errors++; $display("FAIL strobe_overlap: got %b expected 0", both_hi); end
  endtask

  initial begin
    for (int a = 0; a < 128; a++) rom[a] = {6'(a), 6'((a % 63) + 1)};
    test_reset();
    test_basic();
    test_end_marker();
    test_full();
    test_pause();
    test_reset_mid();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
